mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 114 +++++++++++
 tb/tb_mult_div_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// MULT/DIV sequencing controller: launches DIVMULT, waits LATENCY cycles, loads HI/LO.
// Latency: request accepted in IDLE, md_start next cycle, hilo_load LATENCY+1 cycles after md_start.
// Backpressure: op_ready low while busy; op_valid is ignored until IDLE. stall = mf_req & busy.
// Optional feature: define MD_DIV0_ABORT_EN to abort DIV-by-zero with a div0_exc pulse.
module mult_div_ctrl #(
    parameter int LATENCY = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic op_valid,
    input  logic op_sel,
    output logic op_ready,
    output logic md_start,
    output logic md_control,
    input  logic md_div0,
    output logic hilo_load,
    input  logic mf_req,
    output logic stall,
    output logic busy,
    output logic done,
    output logic div0_exc
);

    // Counter reload value; the WAIT state spans LATENCY cycles (LATENCY-1 down to 0).
    localparam logic [5:0] LC_CNT_LOAD = 6'(LATENCY - 1);

`ifdef MD_DIV0_ABORT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ABORT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3
    } state_t;
`endif

    state_t     r_state;
    logic [5:0] r_cnt;
    logic       r_md_control;

`ifndef MD_DIV0_ABORT_EN
    // Divide-by-zero flag has no effect when aborts are disabled.
    logic w_unused_div0;
    assign w_unused_div0 = md_div0;
`endif

    // Controller FSM: accept, launch, count down the DIVMULT latency, then write or abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 6'd0;
            r_md_control <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_md_control <= op_sel;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= LC_CNT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
`ifdef MD_DIV0_ABORT_EN
                    // Only a DIV can raise divide-by-zero; MULT ignores the flag.
                    if (r_md_control && md_div0)
                        r_state <= S_ABORT;
                    else
`endif
                    if (r_cnt == 6'd0)
                        r_state <= S_WRITE;
                    else
                        r_cnt <= r_cnt - 6'd1;
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                end
`ifdef MD_DIV0_ABORT_EN
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pulse and status outputs are pure state decodes so reset clears them immediately.
    assign busy       = (r_state != S_IDLE);
    assign op_ready   = ~busy;
    assign md_start   = (r_state == S_START);
    assign hilo_load  = (r_state == S_WRITE);
    assign done       = (r_state == S_WRITE);
    assign md_control = r_md_control;
    // In IDLE busy is 0, so an MF read alongside a new request does not stall and sees old HI/LO.
    assign stall      = mf_req & busy;
`ifdef MD_DIV0_ABORT_EN
    assign div0_exc   = (r_state == S_ABORT);
`else
    assign div0_exc   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl with LATENCY=33; cycle 0 is the IDLE cycle a request is presented.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled there as well.
// Build with or without MD_DIV0_ABORT_EN; the div-by-zero expectations follow the macro.
module tb_mult_div_ctrl;

    localparam int LAT = 33;

    logic clk;
    logic reset;
    logic op_valid;
    logic op_sel;
    logic op_ready;
    logic md_start;
    logic md_control;
    logic md_div0;
    logic hilo_load;
    logic mf_req;
    logic stall;
    logic busy;
    logic done;
    logic div0_exc;

    int n_checks;
    int n_errors;

    // Per-window observation tallies filled by watch().
    int w_first_hilo;
    int w_hilo;
    int w_start;
    int w_div0;
    int w_stall;
    int w_ctl;

    mult_div_ctrl #(.LATENCY(LAT)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_sel     (op_sel),
        .op_ready   (op_ready),
        .md_start   (md_start),
        .md_control (md_control),
        .md_div0    (md_div0),
        .hilo_load  (hilo_load),
        .mf_req     (mf_req),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .div0_exc   (div0_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance through cycles c_from..c_to, tallying output activity; ends inside cycle c_to.
    task automatic watch(input int c_from, input int c_to);
        w_first_hilo = -1;
        w_hilo  = 0;
        w_start = 0;
        w_div0  = 0;
        w_stall = 0;
        w_ctl   = 0;
        for (int c = c_from; c <= c_to; c++) begin
            tick();
            if (hilo_load) begin
                if (w_first_hilo < 0) w_first_hilo = c;
                w_hilo++;
            end
            if (md_start)   w_start++;
            if (div0_exc)   w_div0++;
            if (stall)      w_stall++;
            if (md_control) w_ctl++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        op_valid = 1'b0;
        op_sel   = 1'b0;
        md_div0  = 1'b0;
        mf_req   = 1'b1;
        #3;
        // Reset state
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_md_start", 32'(md_start), 32'd0);
        check("rst_hilo", 32'(hilo_load), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div0", 32'(div0_exc), 32'd0);
        check("rst_md_control", 32'(md_control), 32'd0);
        repeat (2) tick();

        // Scenario 1: MULT right after reset release, accepted on the first edge.
        reset    = 1'b1;
        mf_req   = 1'b0;
        op_valid = 1'b1;
        op_sel   = 1'b0;
        #1;
        check("s1_c0_op_ready", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        check("s1_c1_md_start", 32'(md_start), 32'd1);
        check("s1_c1_busy", 32'(busy), 32'd1);
        check("s1_c1_op_ready", 32'(op_ready), 32'd0);
        watch(2, LAT + 1);
        check("s1_wait_no_hilo", 32'(w_hilo), 32'd0);
        check("s1_wait_no_start", 32'(w_start), 32'd0);
        tick();
        check("s1_c35_hilo", 32'(hilo_load), 32'd1);
        check("s1_c35_done", 32'(done), 32'd1);
        check("s1_c35_busy", 32'(busy), 32'd1);
        tick();
        check("s1_c36_op_ready", 32'(op_ready), 32'd1);
        check("s1_c36_hilo", 32'(hilo_load), 32'd0);
        check("s1_c36_done", 32'(done), 32'd0);

        // Scenario 2: DIV, then a MULT request held during the DIV.
        op_valid = 1'b1;
        op_sel   = 1'b1;
        #1;
        tick();
        op_sel = 1'b0;
        check("s2_c1_md_start", 32'(md_start), 32'd1);
        check("s2_c1_md_control", 32'(md_control), 32'd1);
        watch(2, LAT + 1);
        check("s2_wait_no_start", 32'(w_start), 32'd0);
        check("s2_wait_ctl_held", 32'(w_ctl), 32'(LAT));
        check("s2_wait_no_hilo", 32'(w_hilo), 32'd0);
        tick();
        check("s2_c35_hilo", 32'(hilo_load), 32'd1);
        check("s2_c35_md_control", 32'(md_control), 32'd1);
        check("s2_c35_op_ready", 32'(op_ready), 32'd0);
        tick();
        check("s2_c36_op_ready", 32'(op_ready), 32'd1);
        check("s2_c36_md_control", 32'(md_control), 32'd1);
        // Scenario 3 rides on the back-to-back MULT accepted in cycle 36.
        tick();
        op_valid = 1'b0;
        check("s3_c1_md_start", 32'(md_start), 32'd1);
        check("s3_c1_md_control", 32'(md_control), 32'd0);
        watch(2, 9);
        check("s3_no_stall_before_mf", 32'(w_stall), 32'd0);
        tick();
        mf_req = 1'b1;
        #1;
        check("s3_c10_stall", 32'(stall), 32'd1);
        watch(11, LAT + 1);
        check("s3_wait_stall_cnt", 32'(w_stall), 32'(LAT + 1 - 10));
        tick();
        check("s3_c35_hilo", 32'(hilo_load), 32'd1);
        check("s3_c35_stall", 32'(stall), 32'd1);
        tick();
        check("s3_c36_stall", 32'(stall), 32'd0);
        // MF read together with a new request in IDLE: accepted, no stall.
        op_valid = 1'b1;
        op_sel   = 1'b1;
        #1;
        check("s3_idle_mf_op_stall", 32'(stall), 32'd0);
        check("s3_idle_mf_op_ready", 32'(op_ready), 32'd1);

        // Scenario 4: DIV with divide-by-zero reported in cycle 5.
        tick();
        check("s4_c1_md_start", 32'(md_start), 32'd1);
        check("s4_c1_stall", 32'(stall), 32'd1);
        mf_req   = 1'b0;
        op_valid = 1'b0;
        watch(2, 4);
        tick();
        md_div0 = 1'b1;
        tick();
        md_div0 = 1'b0;
`ifdef MD_DIV0_ABORT_EN
        #1;
        check("s4_c6_div0_exc", 32'(div0_exc), 32'd1);
        check("s4_c6_hilo", 32'(hilo_load), 32'd0);
        check("s4_c6_busy", 32'(busy), 32'd1);
        tick();
        check("s4_c7_op_ready", 32'(op_ready), 32'd1);
        check("s4_c7_div0_exc", 32'(div0_exc), 32'd0);
        watch(8, 40);
        check("s4_after_no_hilo", 32'(w_hilo), 32'd0);
        check("s4_after_no_div0", 32'(w_div0), 32'd0);
`else
        #1;
        check("s4_c6_div0_exc", 32'(div0_exc), 32'd0);
        watch(7, LAT + 1);
        check("s4_wait_no_div0", 32'(w_div0), 32'd0);
        check("s4_wait_no_hilo", 32'(w_hilo), 32'd0);
        tick();
        check("s4_c35_hilo", 32'(hilo_load), 32'd1);
        tick();
        check("s4_c36_op_ready", 32'(op_ready), 32'd1);
`endif

        // MULT with md_div0 raised: flag ignored, normal completion.
        op_valid = 1'b1;
        op_sel   = 1'b0;
        #1;
        tick();
        op_valid = 1'b0;
        watch(2, 4);
        tick();
        md_div0 = 1'b1;
        watch(6, LAT + 1);
        check("s4m_no_div0", 32'(w_div0), 32'd0);
        check("s4m_no_early_hilo", 32'(w_hilo), 32'd0);
        tick();
        check("s4m_c35_hilo", 32'(hilo_load), 32'd1);
        md_div0 = 1'b0;
        tick();
        check("s4m_c36_op_ready", 32'(op_ready), 32'd1);

        // Scenario 5: asynchronous reset in cycle 20 of a DIV.
        op_valid = 1'b1;
        op_sel   = 1'b1;
        #1;
        tick();
        op_valid = 1'b0;
        watch(2, 19);
        tick();
        mf_req = 1'b1;
        #1;
        check("s5_pre_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_stall", 32'(stall), 32'd0);
        check("s5_rst_op_ready", 32'(op_ready), 32'd1);
        check("s5_rst_md_control", 32'(md_control), 32'd0);
        check("s5_rst_hilo", 32'(hilo_load), 32'd0);
        mf_req   = 1'b0;
        op_valid = 1'b1;
        op_sel   = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        op_valid = 1'b0;
        check("s5_c21_md_start", 32'(md_start), 32'd1);
        watch(22, 20 + LAT + 1);
        check("s5_no_stale_hilo", 32'(w_hilo), 32'd0);
        tick();
        check("s5_new_hilo", 32'(hilo_load), 32'd1);
        tick();
        check("s5_end_op_ready", 32'(op_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
